// File: rtl/sub_word.sv
// AES SubWord: four parallel forward S-box lookups with a one-cycle registered result.
// Words use big-endian bit numbering: bit 0 is the MSB, byte 0 occupies bits [0:7].

module sub_word_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    // Entry i of the table is S(i); row r lists S(16r) through S(16r+15).
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX[a];
endmodule

module sub_word (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [0:31] w_in,
    output logic [0:31] w_out,
    output logic        out_valid
);
    logic [0:31] sub;

    for (genvar k = 0; k < 4; k++) begin : g_byte
        sub_word_sbox u_sbox (
            .a (w_in[8*k +: 8]),
            .s (sub[8*k +: 8])
        );
    end

    // The result register only loads on valid input, so junk on w_in while idle never reaches w_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                w_out <= sub;
        end
    end
endmodule

// File: tb/tb_sub_word.sv
// Directed bench for sub_word; S-box reference is computed from GF(2^8) inversion plus the affine map.

module tb_sub_word;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [0:31] w_in = '0;
    logic [0:31] w_out;
    logic        out_valid;
    int          checks = 0;
    int          errors = 0;

    sub_word dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .w_in      (w_in),
        .w_out     (w_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int x = 1; x < 256; x++)
            if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
        return inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] obs_b;
        logic [7:0] exp_b;

        // Reset held with valid input present
        in_valid = 1'b1;
        w_in     = 32'hffffffff;
        for (int i = 0; i < 3; i++) begin
            step();
            check32("reset_wout", w_out, 32'h00000000);
            check1("reset_ovalid", out_valid, 1'b0);
        end

        // Zero word, then idle
        reset    = 1'b1;
        w_in     = 32'h00000000;
        in_valid = 1'b1;
        step();
        check32("zero_wout", w_out, 32'h63636363);
        check1("zero_ovalid", out_valid, 1'b1);
        in_valid = 1'b0;
        step();
        check32("zero_hold_wout", w_out, 32'h63636363);
        check1("zero_hold_ovalid", out_valid, 1'b0);

        // Key-expansion vectors back-to-back, then cf4f3c09 again ahead of the hold test
        in_valid = 1'b1;
        w_in     = 32'hcf4f3c09;
        step();
        check32("kx0_wout", w_out, 32'h8a84eb01);
        check1("kx0_ovalid", out_valid, 1'b1);
        w_in = 32'h6c76052a;
        step();
        check32("kx1_wout", w_out, 32'h50386be5);
        check1("kx1_ovalid", out_valid, 1'b1);
        w_in = 32'hcf4f3c09;
        step();
        check32("kx2_wout", w_out, 32'h8a84eb01);
        check1("kx2_ovalid", out_valid, 1'b1);

        // Hold with X on w_in while idle
        in_valid = 1'b0;
        w_in     = 'x;
        for (int i = 0; i < 5; i++) begin
            step();
            check32("hold_wout", w_out, 32'h8a84eb01);
            check1("hold_ovalid", out_valid, 1'b0);
        end

        // Hand-computed table spot checks
        check32("ref_s00", 32'(sbox_ref(8'h00)), 32'h63);
        check32("ref_s01", 32'(sbox_ref(8'h01)), 32'h7c);
        check32("ref_s10", 32'(sbox_ref(8'h10)), 32'hca);
        check32("ref_s53", 32'(sbox_ref(8'h53)), 32'hed);
        check32("ref_sff", 32'(sbox_ref(8'hff)), 32'h16);

        // Exhaustive S-box, four consecutive byte values per word, streamed every cycle
        in_valid = 1'b1;
        for (int base = 0; base < 256; base += 4) begin
            b    = 8'(base);
            w_in = {b, 8'(b + 1), 8'(b + 2), 8'(b + 3)};
            step();
            check1("exh_ovalid", out_valid, 1'b1);
            for (int k = 0; k < 4; k++) begin
                obs_b = w_out[8*k +: 8];
                exp_b = sbox_ref(8'(b + 8'(k)));
                checks++;
                assert (obs_b === exp_b) else begin
                    errors++;
                    $error("FAIL exh_byte in=%h pos=%0d observed=%h expected=%h", 8'(b + 8'(k)), k, obs_b, exp_b);
                end
            end
        end

        // Async reset between edges while a result is valid
        w_in = 32'h53535353;
        step();
        check32("pre_arst_wout", w_out, 32'hedededed);
        check1("pre_arst_ovalid", out_valid, 1'b1);
        w_in = 32'h01010101;
        #2;
        reset = 1'b0;
        #1;
        check32("arst_wout", w_out, 32'h00000000);
        check1("arst_ovalid", out_valid, 1'b0);
        step();
        check32("arst_edge_wout", w_out, 32'h00000000);
        check1("arst_edge_ovalid", out_valid, 1'b0);

        // First capture after release
        reset = 1'b1;
        w_in  = 32'h10ff0110;
        step();
        check32("release_wout", w_out, 32'hca167cca);
        check1("release_ovalid", out_valid, 1'b1);
        in_valid = 1'b0;
        step();
        check1("release_idle_ovalid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
